// File: rtl/control_sequencer.sv
// control_sequencer: microcoded T-state sequencer for the 4-bit bus computer.
// Ports:
//   CLK, RESET        clock; asynchronous active-high reset (tstate=1, halted=0)
//   run               1 = sequence, 0 = pause (state held, strobes forced low)
//   opcode, carry     IR opcode nibble and ALU carry flag (carry used by JC only)
//   pc_en/pc_oe/pc_we program counter increment / bus drive / jump load
//   mar_we, ram_oe, ram_we, ir_we, ir_oe, a_we, a_oe, b_we, alu_oe, alu_sub, out_we
//                     register bus strobes, one control word per clock
//   halted, tstate    HLT reached; current step 1..6
module control_sequencer #(
    parameter int OP_W    = 4,
    parameter int VERBOSE = 0
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            run,
    input  logic [OP_W-1:0] opcode,
    input  logic            carry,
    output logic            pc_en,
    output logic            pc_oe,
    output logic            pc_we,
    output logic            mar_we,
    output logic            ram_oe,
    output logic            ram_we,
    output logic            ir_we,
    output logic            ir_oe,
    output logic            a_we,
    output logic            a_oe,
    output logic            b_we,
    output logic            alu_oe,
    output logic            alu_sub,
    output logic            out_we,
    output logic            halted,
    output logic [2:0]      tstate
);
    if (OP_W != 4) begin : g_bad_op_w
        $error("control_sequencer: only OP_W=4 is supported");
    end
    if (VERBOSE != 0 && VERBOSE != 1) begin : g_bad_verbose
        $error("control_sequencer: VERBOSE must be 0 or 1");
    end

    typedef enum logic [2:0] {
        T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5, T6 = 3'd6
    } tstate_e;

    localparam logic [OP_W-1:0] OP_LDA = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);
    localparam logic [OP_W-1:0] OP_STA = OP_W'(4);
    localparam logic [OP_W-1:0] OP_LDI = OP_W'(5);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(6);
    localparam logic [OP_W-1:0] OP_JC  = OP_W'(7);
    localparam logic [OP_W-1:0] OP_OUT = OP_W'(14);
    localparam logic [OP_W-1:0] OP_HLT = OP_W'(15);

    // Control word bit positions, MSB first: pc_en .. out_we.
    localparam logic [13:0] PC_EN   = 14'h2000;
    localparam logic [13:0] PC_OE   = 14'h1000;
    localparam logic [13:0] PC_WE   = 14'h0800;
    localparam logic [13:0] MAR_WE  = 14'h0400;
    localparam logic [13:0] RAM_OE  = 14'h0200;
    localparam logic [13:0] RAM_WE  = 14'h0100;
    localparam logic [13:0] IR_WE   = 14'h0080;
    localparam logic [13:0] IR_OE   = 14'h0040;
    localparam logic [13:0] A_WE    = 14'h0020;
    localparam logic [13:0] A_OE    = 14'h0010;
    localparam logic [13:0] B_WE    = 14'h0008;
    localparam logic [13:0] ALU_OE  = 14'h0004;
    localparam logic [13:0] ALU_SUB = 14'h0002;
    localparam logic [13:0] OUT_WE  = 14'h0001;

    tstate_e     tstate_q, tstate_d;
    logic        halted_q, halted_d;
    logic [13:0] cw, ctl;
    logic        is_nop;

    // Opcodes with no execute steps finish right after fetch.
    assign is_nop = !(opcode inside {OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
                                     OP_JMP, OP_JC, OP_OUT, OP_HLT});

    always_comb begin
        tstate_d = tstate_q;
        halted_d = halted_q;
        cw       = '0;
        case (tstate_q)
            T1: begin
                cw       = PC_OE | MAR_WE;
                tstate_d = T2;
            end
            T2: begin
                cw       = PC_EN;
                tstate_d = T3;
            end
            T3: begin
                cw       = RAM_OE | IR_WE;
                tstate_d = is_nop ? T1 : T4;
            end
            T4: begin
                tstate_d = T1;
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        cw       = IR_OE | MAR_WE;
                        tstate_d = T5;
                    end
                    OP_LDI: cw = IR_OE | A_WE;
                    OP_JMP: cw = IR_OE | PC_WE;
                    OP_JC:  cw = carry ? (IR_OE | PC_WE) : '0;
                    OP_OUT: cw = A_OE | OUT_WE;
                    OP_HLT: begin
                        tstate_d = T4;
                        halted_d = 1'b1;
                    end
                    default: cw = '0;
                endcase
            end
            T5: begin
                tstate_d = T1;
                case (opcode)
                    OP_LDA: cw = RAM_OE | A_WE;
                    OP_STA: cw = A_OE | RAM_WE;
                    OP_ADD, OP_SUB: begin
                        cw       = RAM_OE | B_WE;
                        tstate_d = T6;
                    end
                    default: cw = '0;
                endcase
            end
            T6: begin
                tstate_d = T1;
                cw       = (opcode == OP_ADD || opcode == OP_SUB) ? (ALU_OE | A_WE) : '0;
                cw       = cw | ((opcode == OP_SUB) ? ALU_SUB : '0);
            end
            default: tstate_d = T1;
        endcase
        // Pause and halt freeze everything; the IR is never strobed while paused.
        if (!run || halted_q) begin
            tstate_d = tstate_q;
            halted_d = halted_q;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            tstate_q <= T1;
            halted_q <= 1'b0;
        end else begin
            tstate_q <= tstate_d;
            halted_q <= halted_d;
        end
    end

    assign ctl = (RESET || !run || halted_q) ? '0 : cw;
    assign {pc_en, pc_oe, pc_we, mar_we, ram_oe, ram_we, ir_we, ir_oe,
            a_we, a_oe, b_we, alu_oe, alu_sub, out_we} = ctl;
    assign halted = halted_q;
    assign tstate = tstate_q;
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized self-checking bench against a microcode-table model.
module tb_control_sequencer;
    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       run = 1'b0;
    logic       carry = 1'b0;
    logic [3:0] opcode = 4'd0;
    logic       pc_en, pc_oe, pc_we, mar_we, ram_oe, ram_we, ir_we, ir_oe;
    logic       a_we, a_oe, b_we, alu_oe, alu_sub, out_we, halted;
    logic [2:0] tstate;
    logic [13:0] cw;

    int checks = 0;
    int errors = 0;
    int m_t = 1;
    bit m_h = 1'b0;
    int n;

    localparam logic [13:0] PC_EN   = 14'h2000;
    localparam logic [13:0] PC_OE   = 14'h1000;
    localparam logic [13:0] PC_WE   = 14'h0800;
    localparam logic [13:0] MAR_WE  = 14'h0400;
    localparam logic [13:0] RAM_OE  = 14'h0200;
    localparam logic [13:0] RAM_WE  = 14'h0100;
    localparam logic [13:0] IR_WE   = 14'h0080;
    localparam logic [13:0] IR_OE   = 14'h0040;
    localparam logic [13:0] A_WE    = 14'h0020;
    localparam logic [13:0] A_OE    = 14'h0010;
    localparam logic [13:0] B_WE    = 14'h0008;
    localparam logic [13:0] ALU_OE  = 14'h0004;
    localparam logic [13:0] ALU_SUB = 14'h0002;
    localparam logic [13:0] OUT_WE  = 14'h0001;

    control_sequencer dut (
        .CLK(CLK), .RESET(RESET), .run(run), .opcode(opcode), .carry(carry),
        .pc_en(pc_en), .pc_oe(pc_oe), .pc_we(pc_we), .mar_we(mar_we),
        .ram_oe(ram_oe), .ram_we(ram_we), .ir_we(ir_we), .ir_oe(ir_oe),
        .a_we(a_we), .a_oe(a_oe), .b_we(b_we), .alu_oe(alu_oe),
        .alu_sub(alu_sub), .out_we(out_we), .halted(halted), .tstate(tstate)
    );

    assign cw = {pc_en, pc_oe, pc_we, mar_we, ram_oe, ram_we, ir_we, ir_oe,
                 a_we, a_oe, b_we, alu_oe, alu_sub, out_we};

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge CLK) begin
        chk("bus_onehot", 32'($onehot0({pc_oe, ram_oe, ir_oe, a_oe, alu_oe})), 32'd1);
        chk("pc_en_we_excl", 32'(pc_en & pc_we), 32'd0);
    end

    // Total steps an instruction occupies, fetch included.
    function automatic int ins_len(input logic [3:0] op);
        case (op)
            4'd1, 4'd4: return 5;
            4'd2, 4'd3: return 6;
            4'd5, 4'd6, 4'd7, 4'd14, 4'd15: return 4;
            default: return 3;
        endcase
    endfunction

    // Execute-phase microcode as {T6, T5, T4}.
    function automatic logic [2:0][13:0] exec_seq(input logic [3:0] op, input logic c);
        case (op)
            4'd1:  return {14'd0, RAM_OE | A_WE, IR_OE | MAR_WE};
            4'd2:  return {ALU_OE | A_WE, RAM_OE | B_WE, IR_OE | MAR_WE};
            4'd3:  return {ALU_OE | A_WE | ALU_SUB, RAM_OE | B_WE, IR_OE | MAR_WE};
            4'd4:  return {14'd0, A_OE | RAM_WE, IR_OE | MAR_WE};
            4'd5:  return {14'd0, 14'd0, IR_OE | A_WE};
            4'd6:  return {14'd0, 14'd0, IR_OE | PC_WE};
            4'd7:  return {14'd0, 14'd0, c ? (IR_OE | PC_WE) : 14'd0};
            4'd14: return {14'd0, 14'd0, A_OE | OUT_WE};
            default: return '0;
        endcase
    endfunction

    function automatic logic [13:0] exp_cw();
        logic [2:0][13:0] s;
        if (RESET || !run || m_h) return '0;
        if (m_t == 1) return PC_OE | MAR_WE;
        if (m_t == 2) return PC_EN;
        if (m_t == 3) return RAM_OE | IR_WE;
        s = exec_seq(opcode, carry);
        return s[m_t-4];
    endfunction

    task automatic model_next();
        if (RESET) begin
            m_t = 1;
            m_h = 1'b0;
        end else if (run && !m_h) begin
            if (m_t < 3) m_t++;
            else if (opcode == 4'd15 && m_t == 4) m_h = 1'b1;
            else if (m_t >= ins_len(opcode)) m_t = 1;
            else m_t++;
        end
    endtask

    // Entered 1 time unit after a rising edge with inputs already driven.
    task automatic tick(input string tag);
        #2;
        chk({tag, "_cw"}, 32'(cw), 32'(exp_cw()));
        chk({tag, "_t"}, 32'(tstate), 32'(m_t));
        chk({tag, "_h"}, 32'(halted), 32'(m_h));
        @(posedge CLK);
        model_next();
        #1;
    endtask

    task automatic do_reset(input string tag);
        #2;
        RESET = 1'b1;
        #1;
        chk({tag, "_t"}, 32'(tstate), 32'd1);
        chk({tag, "_h"}, 32'(halted), 32'd0);
        chk({tag, "_cw"}, 32'(cw), 32'd0);
        m_t = 1;
        m_h = 1'b0;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
    endtask

    task automatic run_op(input logic [3:0] op, input logic c, input string tag, output int len);
        for (int i = 0; i < 8 && m_t != 1; i++) tick("align");
        opcode = op;
        carry  = c;
        len    = 0;
        do begin
            tick(tag);
            len++;
        end while (m_t != 1 && len < 8);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(posedge CLK);
        #1;
        chk("rst_t", 32'(tstate), 32'd1);
        chk("rst_h", 32'(halted), 32'd0);
        chk("rst_cw", 32'(cw), 32'd0);
        run = 1'b1;
        #1;
        chk("rst_cw_run", 32'(cw), 32'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        m_t = 1;
        m_h = 1'b0;

        run_op(4'd0, 1'b0, "nop", n);  chk("nop_len", 32'(n), 32'd3);
        run_op(4'd2, 1'b0, "add", n);  chk("add_len", 32'(n), 32'd6);
        run_op(4'd3, 1'b1, "sub", n);  chk("sub_len", 32'(n), 32'd6);
        run_op(4'd7, 1'b1, "jc1", n);  chk("jc1_len", 32'(n), 32'd4);
        run_op(4'd7, 1'b0, "jc0", n);  chk("jc0_len", 32'(n), 32'd4);
        run_op(4'd1, 1'b0, "lda", n);  chk("lda_len", 32'(n), 32'd5);
        run_op(4'd4, 1'b0, "sta", n);  chk("sta_len", 32'(n), 32'd5);
        run_op(4'd5, 1'b0, "ldi", n);  chk("ldi_len", 32'(n), 32'd4);
        run_op(4'd6, 1'b0, "jmp", n);  chk("jmp_len", 32'(n), 32'd4);
        run_op(4'd14, 1'b0, "out", n); chk("out_len", 32'(n), 32'd4);
        run_op(4'd9, 1'b0, "undef", n); chk("undef_len", 32'(n), 32'd3);

        run_op(4'd15, 1'b0, "hlt", n);
        chk("hlt_h", 32'(halted), 32'd1);
        for (int i = 0; i < 10; i++) tick("hlt_hold");
        chk("hlt_t", 32'(tstate), 32'd4);
        chk("hlt_cw", 32'(cw), 32'd0);
        do_reset("hlt_rst");

        opcode = 4'd1;
        carry  = 1'b0;
        for (int i = 0; i < 4; i++) tick("lda_p");
        chk("pause_at5", 32'(tstate), 32'd5);
        run = 1'b0;
        for (int i = 0; i < 3; i++) tick("pause");
        chk("pause_hold", 32'(tstate), 32'd5);
        run = 1'b1;
        tick("resume");
        chk("resume_end", 32'(tstate), 32'd1);

        for (int i = 0; i < 2000; i++) begin
            if (m_h || (m_t == 2 && $urandom_range(0, 39) == 0)) begin
                do_reset("rnd_rst");
            end else begin
                run    = ($urandom_range(0, 7) != 0);
                opcode = 4'($urandom);
                carry  = 1'($urandom);
                tick("rnd");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
